// File: rtl/stage_sequencer_pkg.sv
// Shared stage encoding, strobe bit positions and defaults
// for the stage5 multi-cycle sequencer.
package stage_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_READ_REGS,
    ST_EXECUTE,
    ST_MEMORY,
    ST_WRITEBACK,
    ST_HALTED,
    ST_FAULT
  } stage_t;

  localparam int STAGE_W       = 7;
  localparam int IDX_FETCH     = 0;
  localparam int IDX_DECODE    = 1;
  localparam int IDX_READ_REGS = 2;
  localparam int IDX_EXECUTE   = 3;
  localparam int IDX_MEMORY    = 4;
  localparam int IDX_WRITEBACK = 5;
  localparam int IDX_HALTED    = 6;

  localparam int unsigned DEFAULT_WAIT_LIMIT = 255;
  localparam int          TIMER_W            = 16;

  // FAULT maps to all-zero strobes.
  function automatic logic [STAGE_W-1:0] stage_onehot(
    input stage_t s
  );
    logic [STAGE_W-1:0] v;
    v = '0;
    case (s)
      ST_FETCH:     v[IDX_FETCH]     = 1'b1;
      ST_DECODE:    v[IDX_DECODE]    = 1'b1;
      ST_READ_REGS: v[IDX_READ_REGS] = 1'b1;
      ST_EXECUTE:   v[IDX_EXECUTE]   = 1'b1;
      ST_MEMORY:    v[IDX_MEMORY]    = 1'b1;
      ST_WRITEBACK: v[IDX_WRITEBACK] = 1'b1;
      ST_HALTED:    v[IDX_HALTED]    = 1'b1;
      ST_FAULT:     v                = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/stage_sequencer_wait_timer.sv
// Wait-cycle counter for unanswered memory requests.
// Ports: i_clock, i_reset, i_clear, i_enable in; o_limit_hit out.
module stage_sequencer_wait_timer
  import stage_sequencer_pkg::*;
#(
  parameter int unsigned LIMIT = DEFAULT_WAIT_LIMIT
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_limit_hit
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(LIMIT - 1);

  logic [TIMER_W-1:0] r_count;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Flags the last allowed wait cycle; the FSM only
  // consults it while it is actually waiting.
  assign o_limit_hit = (r_count == LAST);

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle stage FSM with memory handshakes, halt and retire count.
// Ports: clock, reset, imem/dmem ready, is_mem_op, halt/resume in;
//        requests, one-hot stage, status flags, retired_count out.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT  = DEFAULT_WAIT_LIMIT,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   imem_ready,
  input  logic                   dmem_ready,
  input  logic                   is_mem_op,
  input  logic                   halt_request,
  input  logic                   resume,
  output logic                   imem_req,
  output logic                   dmem_req,
  output logic [STAGE_W-1:0]     stage,
  output logic                   is_writeback_stage,
  output logic                   halted,
  output logic                   fault,
  output logic [COUNT_WIDTH-1:0] retired_count
);

  stage_t r_state;
  stage_t w_next;

  logic w_wait_en;
  logic w_wait_clr;
  logic w_limit_hit;

  logic [COUNT_WIDTH-1:0] r_retired;

  stage_sequencer_wait_timer #(
    .LIMIT (WAIT_LIMIT)
  ) u_wait (
    .i_clock     (clock),
    .i_reset     (reset),
    .i_clear     (w_wait_clr),
    .i_enable    (w_wait_en),
    .o_limit_hit (w_limit_hit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_wait_en = 1'b0;
    unique case (r_state)
      ST_FETCH: begin
        // ready beats the timeout in the same cycle
        if (imem_ready) begin
          w_next = ST_DECODE;
        end else begin
          w_wait_en = 1'b1;
          if (w_limit_hit) w_next = ST_FAULT;
        end
      end
      ST_DECODE:    w_next = ST_READ_REGS;
      ST_READ_REGS: w_next = ST_EXECUTE;
      ST_EXECUTE: begin
        w_next = is_mem_op ? ST_MEMORY : ST_WRITEBACK;
      end
      ST_MEMORY: begin
        if (dmem_ready) begin
          w_next = ST_WRITEBACK;
        end else begin
          w_wait_en = 1'b1;
          if (w_limit_hit) w_next = ST_FAULT;
        end
      end
      ST_WRITEBACK: begin
        w_next = halt_request ? ST_HALTED : ST_FETCH;
      end
      ST_HALTED: begin
        if (resume && !halt_request) w_next = ST_FETCH;
      end
      ST_FAULT: w_next = ST_FAULT;
    endcase
  end

  assign w_wait_clr = (w_next != r_state);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_retired <= '0;
    end else if (r_state == ST_WRITEBACK) begin
      r_retired <= r_retired + 1'b1;
    end
  end

  assign stage              = stage_onehot(r_state);
  assign imem_req           = (r_state == ST_FETCH);
  assign dmem_req           = (r_state == ST_MEMORY);
  assign is_writeback_stage = stage[IDX_WRITEBACK];
  assign halted             = stage[IDX_HALTED];
  assign fault              = (r_state == ST_FAULT);
  assign retired_count      = r_retired;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: directed scenarios plus random
// stimulus, all cycles checked against a stage-walk model.
module tb_stage_sequencer;

  localparam int WL = 4;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          imem_ready = 1'b0;
  logic          dmem_ready = 1'b0;
  logic          is_mem_op = 1'b0;
  logic          halt_request = 1'b0;
  logic          resume = 1'b0;
  logic          imem_req;
  logic          dmem_req;
  logic [6:0]    stage;
  logic          is_writeback_stage;
  logic          halted;
  logic          fault;
  logic [CW-1:0] retired_count;

  always #5 clock = ~clock;

  stage_sequencer #(
    .WAIT_LIMIT  (WL),
    .COUNT_WIDTH (CW)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .imem_ready         (imem_ready),
    .dmem_ready         (dmem_ready),
    .is_mem_op          (is_mem_op),
    .halt_request       (halt_request),
    .resume             (resume),
    .imem_req           (imem_req),
    .dmem_req           (dmem_req),
    .stage              (stage),
    .is_writeback_stage (is_writeback_stage),
    .halted             (halted),
    .fault              (fault),
    .retired_count      (retired_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model: position in the stage list (7 = fault),
  // unanswered wait cycles and retired instructions
  int m_idx  = 0;
  int m_wait = 0;
  int m_ret  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      m_idx = 0; m_wait = 0; m_ret = 0;
    end else begin
      case (m_idx)
        0, 4: begin
          if ((m_idx == 0) ? imem_ready : dmem_ready) begin
            m_idx = m_idx + 1; m_wait = 0;
          end else if (m_wait == WL - 1) begin
            m_idx = 7; m_wait = 0;
          end else begin
            m_wait++;
          end
        end
        1, 2: m_idx++;
        3: m_idx = is_mem_op ? 4 : 5;
        5: begin
          m_ret = (m_ret + 1) % (1 << CW);
          m_idx = halt_request ? 6 : 0;
        end
        6: if (resume && !halt_request) m_idx = 0;
        default: ;
      endcase
    end
  endtask

  task automatic check_outputs();
    logic [6:0] es;
    logic [4:0] ec;
    es = (m_idx == 7) ? 7'd0 : 7'(1 << m_idx);
    ec = {m_idx == 0, m_idx == 4, m_idx == 5,
          m_idx == 6, m_idx == 7};
    chk("stage", 32'(stage), 32'(es));
    chk("ctrl",
        32'({imem_req, dmem_req, is_writeback_stage,
             halted, fault}),
        32'(ec));
    chk("retired", 32'(retired_count), 32'(m_ret));
  endtask

  task automatic step(input logic r, input logic im,
                      input logic dm, input logic mo,
                      input logic hr, input logic rs);
    reset = r; imem_ready = im; dmem_ready = dm;
    is_mem_op = mo; halt_request = hr; resume = rs;
    model_edge();
    @(posedge clock);
    #1;
    check_outputs();
  endtask

  logic [6:0] seq [5] = '{7'h02, 7'h04, 7'h08, 7'h20, 7'h01};

  initial begin
    int cnt;

    // reset state
    step(1, 0, 0, 0, 0, 0);
    chk("rst_stage", 32'(stage), 32'h01);
    chk("rst_flags", 32'({dmem_req, halted, fault}), 0);
    chk("rst_ret", 32'(retired_count), 0);

    // back-to-back non-memory instructions
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      step(0, 1, 0, 0, 0, 0);
      if (i < 5) chk("seq", 32'(stage), 32'(seq[i]));
      cnt += int'(is_writeback_stage);
    end
    chk("ret15", 32'(retired_count), 3);
    chk("wb_pulses", cnt, 3);

    // memory op with 3 wait cycles: latency 9
    cnt = 0;
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    cnt += int'(dmem_req);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      cnt += int'(dmem_req);
    end
    step(0, 0, 1, 0, 0, 0);
    chk("mem_wb", 32'(stage), 32'h20);
    step(0, 0, 0, 0, 0, 0);
    chk("mem_cycles", cnt, 4);
    chk("mem_lat9", 32'(stage), 32'h01);
    chk("mem_ret", 32'(retired_count), 4);

    // fetch timeout
    step(1, 0, 0, 0, 0, 0);
    cnt = int'(imem_req);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0);
      cnt += int'(imem_req);
    end
    chk("imem_cycles", cnt, 4);
    chk("fault_set", 32'(fault), 1);
    chk("fault_stage", 32'(stage), 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0, 1);
    chk("fault_sticky", 32'(fault), 1);
    step(1, 0, 0, 0, 0, 0);
    chk("fault_clr",
        32'({stage, fault}), 32'({7'h01, 1'b0}));
    chk("fault_ret", 32'(retired_count), 0);

    // ready on the last allowed fetch cycle
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("late_ready", 32'({stage, fault}),
        32'({7'h02, 1'b0}));

    // halt / resume
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("halt_in", 32'({halted, imem_req, dmem_req}),
        32'(3'b100));
    step(0, 1, 1, 0, 1, 1);
    chk("halt_hold", 32'(halted), 1);
    step(0, 0, 0, 0, 0, 1);
    chk("resume", 32'(stage), 32'h01);

    // reset in MEMORY
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("mem_req", 32'(dmem_req), 1);
    step(1, 0, 1, 0, 0, 0);
    chk("rst_mem", 32'({dmem_req, stage}),
        32'({1'b0, 7'h01}));
    chk("rst_mem_ret", 32'(retired_count), 0);

    // counter wrap at 2^CW
    for (int i = 0; i < 80; i++) begin
      step(0, 1, 0, 0, 0, 0);
      if (i == 74) chk("ret_15", 32'(retired_count), 15);
    end
    chk("ret_wrap", 32'(retired_count), 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(99) < 2,
           $urandom_range(99) < 70,
           $urandom_range(99) < 60,
           $urandom_range(1) == 1,
           $urandom_range(99) < 15,
           $urandom_range(99) < 35);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Multi-cycle control FSM for the stage5 core. Steps each instruction through FETCH, DECODE, READ_REGS, EXECUTE, optional MEMORY, and WRITEBACK.
- Drives one-hot stage strobes, including is_writeback_stage, which advances the program counter.
- Handles instruction- and data-memory ready handshakes with a bounded wait timeout, halt/resume, and a retired-instruction counter.

Parameters:
- WAIT_LIMIT, 255: maximum cycles spent in FETCH or MEMORY without ready before entering FAULT (range 1..65535).
- COUNT_WIDTH, 32: width of retired_count.

Ports:
- clock  input  1  single system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; one clock with reset high fully initialises the block.
- imem_ready  input  1  instruction memory has valid data this cycle.
- dmem_ready  input  1  data memory access completes this cycle.
- is_mem_op  input  1  decoder flag: current instruction is a load or store; sampled in EXECUTE.
- halt_request  input  1  halt after the current instruction retires; sampled in WRITEBACK.
- resume  input  1  leave HALTED.
- imem_req  output  1  high while in FETCH.
- dmem_req  output  1  high while in MEMORY.
- stage  output  7  one-hot: [0]FETCH [1]DECODE [2]READ_REGS [3]EXECUTE [4]MEMORY [5]WRITEBACK [6]HALTED; all zero in FAULT.
- is_writeback_stage  output  1  equals stage[5]; connects to the program counter.
- halted  output  1  equals stage[6].
- fault  output  1  high in FAULT; sticky until reset.
- retired_count  output  COUNT_WIDTH  instructions retired since reset.

Behaviour:
- Outputs form a Moore decode of the registered state, with no combinational input-to-output paths.
- Reset values:
  - state = FETCH, so imem_req=1 and stage=7'b0000001 in the first cycle after reset.
  - dmem_req=0, halted=0, fault=0, retired_count=0, wait counter=0.
- Reset asserted mid-instruction:
  - Abandons the instruction and drops any pending request at that edge.
  - Does not count the instruction as retired.
- FETCH: on imem_ready go to DECODE; otherwise stay and increment the wait counter.
- DECODE, READ_REGS: exactly 1 cycle each, then advance to the next stage.
- EXECUTE: 1 cycle. If is_mem_op=1 go to MEMORY, else go to WRITEBACK.
- MEMORY: on dmem_ready go to WRITEBACK; otherwise stay and increment the wait counter.
- WRITEBACK: exactly 1 cycle.
  - retired_count increments at the exiting edge and wraps modulo 2^COUNT_WIDTH.
  - If halt_request=1 go to HALTED, else go to FETCH.
- HALTED: leave for FETCH when resume=1 and halt_request=0; otherwise stay.
- FAULT: terminal. Only reset exits it; no strobes, no requests, counter frozen.
- Wait counter:
  - Clears on every state transition.
  - In FETCH/MEMORY without ready, if the counter equals WAIT_LIMIT-1, next state = FAULT. FAULT therefore follows after exactly WAIT_LIMIT unanswered cycles.
  - If ready arrives in the same cycle as the limit, ready wins and the normal transition happens.
- Latency with zero-wait memory (ready in the first cycle):
  - Non-memory instruction: 5 cycles.
  - Memory instruction: 6 cycles.
  - Each memory wait cycle adds 1.
- is_writeback_stage is high exactly one cycle per retired instruction and never in HALTED or FAULT.
- Inputs are ignored outside the state that samples them: imem_ready outside FETCH, dmem_ready outside MEMORY, is_mem_op outside EXECUTE, halt_request outside WRITEBACK and HALTED.

Decomposition:
- Shared definitions package (definitions.vh) holds:
  - stage_t enum: FETCH, DECODE, READ_REGS, EXECUTE, MEMORY, WRITEBACK, HALTED, FAULT.
  - Stage bit-index constants.
  - Default WAIT_LIMIT constant.
- One sub-module, wait_timer (clear, enable, limit_hit, 16-bit counter), instantiated once.
- The FSM and retired counter live in stage_sequencer.

Test Plan:
- Reset, then imem_ready=1 always, is_mem_op=0 → stage sequence 01,02,04,08,20,01 (hex); is_writeback_stage pulses every 5th cycle; retired_count=3 after 15 cycles.
- is_mem_op=1, dmem_ready low for 3 MEMORY cycles then high → MEMORY lasts 4 cycles, dmem_req high all 4; instruction latency 9; retired_count+1.
- WAIT_LIMIT=4, imem_ready held 0 → imem_req high 4 cycles, then fault=1, stage=0; fault persists until reset; reset → stage=01, fault=0, retired_count=0.
- WAIT_LIMIT=4, imem_ready rises in the 4th FETCH cycle → DECODE next, no fault.
- halt_request=1 during WRITEBACK → HALTED, halted=1, no requests. resume=1 with halt_request=1 → stays HALTED. resume=1 with halt_request=0 → FETCH next cycle.
- Reset asserted in MEMORY with dmem_req=1 → next cycle dmem_req=0, stage=01, retired_count=0. Separately, preload COUNT_WIDTH=4 and retire 16 instructions → retired_count wraps to 0.
